// File: rtl/mux_pipe_nto1.sv
// mux_pipe_nto1: NUM_IN-way, WIDTH-bit registered select with a valid/ready
// handshake over a 2-entry skid buffer (main + skid). Out-of-range selects
// forward a zero word flagged by out_sel_err. flush empties the buffer.
module mux_pipe_nto1 #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Reject configurations where the select cannot address every input.
  if (NUM_IN < 2 || NUM_IN > (1 << SEL_W)) begin : g_bad_cfg
    $error("mux_pipe_nto1: NUM_IN must be in 2..2**SEL_W");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] slice [NUM_IN];
  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic             in_xfer;
  logic             out_xfer;

  // Unpack the flat input bus into one word per input.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_slice
    assign slice[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Decode the select by explicit compare so unused codes yield 0, never X.
  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_word = slice[k];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // Occupancy FSM: decide next state and which register captures the word.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_data_d = sel_word;
          main_err_d  = sel_err;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_data_d = sel_word;
          main_err_d  = sel_err;
        end else if (in_xfer) begin
          skid_data_d = sel_word;
          skid_err_d  = sel_err;
          state_d     = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any load; the visible word keeps its last value.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = main_data_q;
      main_err_d  = main_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = main_data_q;
  assign out_sel_err = main_err_q;

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Directed and randomized checks for mux_pipe_nto1 over three configurations.
module tb_mux_pipe_nto1;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  // Instance A: WIDTH=5, NUM_IN=2, SEL_W=1
  logic [9:0] a_in_data;
  logic       a_in_sel, a_in_valid, a_in_ready, a_flush;
  logic [4:0] a_out_data;
  logic       a_out_sel_err, a_out_valid, a_out_ready;
  // Instance B: WIDTH=5, NUM_IN=4, SEL_W=2
  logic [19:0] b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid, b_in_ready, b_flush;
  logic [4:0]  b_out_data;
  logic        b_out_sel_err, b_out_valid, b_out_ready;
  // Instance C: WIDTH=5, NUM_IN=3, SEL_W=2
  logic [14:0] c_in_data;
  logic [1:0]  c_in_sel;
  logic        c_in_valid, c_in_ready, c_flush;
  logic [4:0]  c_out_data;
  logic        c_out_sel_err, c_out_valid, c_out_ready;

  mux_pipe_nto1 #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_sel_err(a_out_sel_err),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );
  mux_pipe_nto1 #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_sel_err(b_out_sel_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );
  mux_pipe_nto1 #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .in_data(c_in_data), .in_sel(c_in_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .flush(c_flush),
    .out_data(c_out_data), .out_sel_err(c_out_sel_err),
    .out_valid(c_out_valid), .out_ready(c_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp_stream [4];
    logic [5:0] q [$];
    logic [5:0] front;
    logic [4:0] w;
    logic       e;
    bit         do_in, do_out;

    checks = 0;
    errors = 0;
    exp_stream = '{5'd3, 5'd7, 5'd11, 5'd19};
    reset_n = 1'b0;
    a_in_data = '0; a_in_sel = '0; a_in_valid = 0; a_flush = 0; a_out_ready = 0;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 0; b_flush = 0; b_out_ready = 0;
    c_in_data = '0; c_in_sel = '0; c_in_valid = 0; c_flush = 0; c_out_ready = 0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // Reset / idle values
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_data", 32'(a_out_data), 0);
    check("rst_sel_err", 32'(a_out_sel_err), 0);
    check("rst_in_ready", 32'(a_in_ready), 1);

    // Backpressure: A=0A then B=15 with out_ready low
    a_in_data = {5'h15, 5'h0A};
    a_in_valid = 1; a_in_sel = 0;
    step();
    check("bp_valid_a", 32'(a_out_valid), 1);
    check("bp_data_a", 32'(a_out_data), 'h0A);
    check("bp_ready_one", 32'(a_in_ready), 1);
    a_in_sel = 1;
    step();
    check("bp_ready_full", 32'(a_in_ready), 0);
    check("bp_hold_a", 32'(a_out_data), 'h0A);
    a_in_valid = 0;
    step();
    check("bp_hold_a2", 32'(a_out_data), 'h0A);
    check("bp_ready_full2", 32'(a_in_ready), 0);
    a_out_ready = 1;
    step();
    check("bp_data_b", 32'(a_out_data), 'h15);
    check("bp_valid_b", 32'(a_out_valid), 1);
    check("bp_ready_back", 32'(a_in_ready), 1);
    step();
    check("bp_drained", 32'(a_out_valid), 0);
    a_out_ready = 0;

    // Asynchronous reset mid-cycle, with a word held in the buffer
    a_in_data = {5'h15, 5'h0A};
    a_in_valid = 1; a_in_sel = 1;
    step();
    a_in_valid = 0;
    check("pre_rst_valid", 32'(a_out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(a_out_valid), 0);
    check("async_rst_data", 32'(a_out_data), 0);
    check("async_rst_ready", 32'(a_in_ready), 1);
    #2 reset_n = 1'b1;
    step();
    check("post_rst_valid", 32'(a_out_valid), 0);

    // Flush while FULL with a competing input
    a_in_valid = 1; a_in_sel = 0;
    step();
    a_in_sel = 1;
    step();
    check("fl_full", 32'(a_in_ready), 0);
    a_in_data = {5'h1F, 5'h07};
    a_in_sel = 0; a_flush = 1;
    step();
    a_flush = 0; a_in_valid = 0;
    check("fl_valid", 32'(a_out_valid), 0);
    check("fl_ready", 32'(a_in_ready), 1);
    a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_ghost", 32'(a_out_valid), 0);
    end
    a_in_valid = 1; a_in_sel = 1;
    step();
    a_in_valid = 0;
    check("fl_next_valid", 32'(a_out_valid), 1);
    check("fl_next_data", 32'(a_out_data), 'h1F);
    step();
    check("fl_next_taken", 32'(a_out_valid), 0);
    // Flush while ONE with a same-cycle input transfer
    a_out_ready = 0;
    a_in_valid = 1; a_in_sel = 0;
    step();
    a_in_sel = 1; a_flush = 1;
    step();
    a_flush = 0; a_in_valid = 0;
    check("fl1_valid", 32'(a_out_valid), 0);
    check("fl1_ready", 32'(a_in_ready), 1);
    step();
    check("fl1_stays_empty", 32'(a_out_valid), 0);

    // Streaming on the 4-input instance
    b_in_data = {5'd19, 5'd11, 5'd7, 5'd3};
    b_out_ready = 1; b_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_in_sel = 2'(i);
      step();
      check("st_valid", 32'(b_out_valid), 1);
      check("st_data", 32'(b_out_data), 32'(exp_stream[i]));
      check("st_err", 32'(b_out_sel_err), 0);
      check("st_ready", 32'(b_in_ready), 1);
    end
    b_in_valid = 0;
    step();
    check("st_done", 32'(b_out_valid), 0);

    // Out-of-range select on the 3-input instance
    c_in_data = {5'd9, 5'd22, 5'd14};
    c_out_ready = 1; c_in_valid = 1; c_in_sel = 3;
    step();
    check("oor_valid", 32'(c_out_valid), 1);
    check("oor_data", 32'(c_out_data), 0);
    check("oor_err", 32'(c_out_sel_err), 1);
    c_in_sel = 2;
    step();
    check("sel2_data", 32'(c_out_data), 9);
    check("sel2_err", 32'(c_out_sel_err), 0);
    c_in_valid = 0;
    step();
    check("oor_drained", 32'(c_out_valid), 0);

    // Random traffic on the 3-input instance against a queue model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rnd_valid", 32'(c_out_valid), 32'(q.size() > 0));
      check("rnd_ready", 32'(c_in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        front = q[0];
        check("rnd_data", 32'(c_out_data), 32'(front[4:0]));
        check("rnd_err", 32'(c_out_sel_err), 32'(front[5]));
      end
      c_in_valid  = 1'($urandom);
      c_in_sel    = 2'($urandom);
      c_in_data   = 15'($urandom);
      c_out_ready = 1'($urandom);
      do_out = (q.size() > 0) && c_out_ready;
      do_in  = (q.size() < 2) && c_in_valid;
      if (c_in_sel < 3) begin
        w = c_in_data[c_in_sel*5 +: 5];
        e = 1'b0;
      end else begin
        w = 5'd0;
        e = 1'b1;
      end
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back({e, w});
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_pipe_nto1.md
Name: mux_pipe_nto1

Overview:
- Parametrised successor to the team's fixed-width 2:1 datapath muxes: NUM_IN-way, WIDTH-bit select, registered output.
- Sits between pipeline stages, e.g. register-destination and writeback-source select, and decouples producer from consumer.
- Uses a valid/ready handshake over a 2-entry skid buffer.
- Adds out-of-range select detection and a synchronous pipeline flush.

Parameters:
- WIDTH, 5, bit width of each data input and of out_data.
- NUM_IN, 2, number of data inputs; legal range 2..2**SEL_W.
- SEL_W, 1, width of in_sel.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to forward.
- in_valid  input  1  producer presents in_data/in_sel this cycle.
- in_ready  output  1  block accepts a transfer this cycle; registered.
- flush  input  1  synchronous discard of all buffered entries.
- out_data  output  WIDTH  selected word; registered.
- out_sel_err  output  1  travels with out_data; 1 = in_sel was >= NUM_IN.
- out_valid  output  1  out_data/out_sel_err valid.
- out_ready  input  1  consumer accepts the output this cycle.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low; assertion takes effect immediately and is independent of clk.
- Reset values: out_valid=0, out_data=0, out_sel_err=0, in_ready=1, skid entry empty. All state returns to EMPTY.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Select decode, done at accept time:
  - in_sel < NUM_IN: word = slice in_sel, err = 0.
  - otherwise: word = 0, err = 1.
  - No X propagation for unused select codes.
- Storage: a main register (drives the outputs) and one skid register.
- State machine, by occupancy:
  - EMPTY:
    - input transfer -> load main, go to ONE.
  - ONE:
    - input and output transfer together -> reload main with the new word, stay ONE.
    - input transfer only -> load skid, go to FULL.
    - output transfer only -> go to EMPTY.
    - neither -> hold.
  - FULL:
    - output transfer -> main takes skid, go to ONE.
    - otherwise hold.
    - in_ready=0, so no input transfer can occur.
- in_ready is registered: in_ready = 1 in EMPTY and ONE, 0 in FULL. It is computed from next state, so it is 0 in the cycle after entering FULL and returns to 1 the cycle after leaving FULL.
- Latency: 1 cycle from input transfer to out_valid when the block is empty.
- Throughput: 1 word/cycle with out_ready held high.
- Ordering: strict FIFO order is preserved; no word is dropped or duplicated while not flushed.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sel_err hold stable.
- Flush:
  - Next state EMPTY, out_valid=0, in_ready=1.
  - A same-cycle input transfer is discarded; flush has priority.
  - A same-cycle output transfer still counts as taken by the consumer.
  - out_data/out_sel_err keep their last values; they are don't-care while out_valid=0.
- Reset mid-operation: all buffered entries are lost, outputs go to reset values immediately, and operation restarts from EMPTY.
- Elaboration: NUM_IN > 2**SEL_W or NUM_IN < 2 is a configuration error and must be caught at elaboration.

Test Plan:
- Reset/idle: WIDTH=5, NUM_IN=2. Assert reset_n=0 mid-cycle -> out_valid=0, out_data=0, in_ready=1 immediately, without waiting for a clk edge.
- Streaming: NUM_IN=4, SEL_W=2, out_ready=1. Inputs {3,7,11,19}, sel sequence 0,1,2,3 over 4 cycles -> out_data 3,7,11,19 on consecutive cycles, each one cycle after its input, out_sel_err=0.
- Backpressure/skid: out_ready=0. Send A=5'h0A then B=5'h15 -> in_ready=0 after B. out_data holds 5'h0A. Raise out_ready -> out 5'h0A then 5'h15, in_ready returns to 1.
- Out-of-range select: NUM_IN=3, SEL_W=2, in_sel=3 -> out_data=0, out_sel_err=1. Following in_sel=2 -> slice 2, out_sel_err=0.
- Flush: FULL state with in_valid=1 and flush=1 in the same cycle -> next cycle out_valid=0, in_ready=1. None of the three words (main, skid, incoming) ever appear.
- Random: 10k cycles of random valid/ready/sel against a queue reference model -> order preserved and no loss/duplication; out_data stable whenever out_valid=1 && out_ready=0.
